// File: rtl/corr_event_collector.sv
// Correlator event collector: rising-edge detection on CorrSeen, per-channel timestamps,
// an event FIFO drained by the CPU over the correlator register bus, and a maskable interrupt.
module corr_event_collector #(
    parameter int NCH   = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr,
    input  logic [31:0]      Wdata,
    input  logic             write,
    input  logic             read,
    output logic [31:0]      Rdata,
    input  logic [NCH-1:0]   CorrSeen,
    input  logic [TSW-1:0]   SampleCount,
    output logic             irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0] ADDR_CTRL    = 32'hFE00_0900;
    localparam logic [31:0] ADDR_PENDING = 32'hFE00_0904;
    localparam logic [31:0] ADDR_MASK    = 32'hFE00_0908;
    localparam logic [31:0] ADDR_STATUS  = 32'hFE00_090C;
    localparam logic [31:0] ADDR_HEAD_TS = 32'hFE00_0910;
    localparam logic [31:0] ADDR_POP     = 32'hFE00_0914;

    logic             enable;
    logic             irq_en;
    logic [NCH-1:0]   pending;
    logic [NCH-1:0]   mask;
    logic [NCH-1:0]   prev_seen;
    logic [NCH-1:0]   arm;
    logic [TSW-1:0]   ts_q [NCH];
    logic [4:0]       fifo_ch [DEPTH];
    logic [TSW-1:0]   fifo_ts [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             overflow;
    logic [7:0]       drop_cnt;

    logic             wr_ctrl, wr_pending, wr_mask, clr_status;
    logic             fifo_empty, fifo_full, pop;
    logic [NCH-1:0]   edges;

    assign wr_ctrl    = write && (addr == ADDR_CTRL);
    assign wr_pending = write && (addr == ADDR_PENDING);
    assign wr_mask    = write && (addr == ADDR_MASK);
    assign clr_status = write && (addr == ADDR_STATUS) && Wdata[16];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CW'(DEPTH));
    assign pop        = read && (addr == ADDR_POP) && !fifo_empty;

    assign edges = CorrSeen & ~prev_seen & {NCH{enable}};

    // Lowest-index armed channel is the one handed to the FIFO this cycle.
    logic             drain_valid;
    logic [4:0]       drain_ch;
    logic [TSW-1:0]   drain_ts;
    logic [NCH-1:0]   drain_oh;

    always_comb begin
        drain_valid = 1'b0;
        drain_ch    = '0;
        drain_ts    = '0;
        drain_oh    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (arm[i] && !drain_valid) begin
                drain_valid = 1'b1;
                drain_ch    = 5'(i);
                drain_ts    = ts_q[i];
                drain_oh[i] = 1'b1;
            end
        end
    end

    // A new edge re-arms a channel only if its previous timestamp is gone (or leaving now).
    logic [NCH-1:0]   arm_kept, arm_new, conflicts, arm_next;
    logic             push_ok, fifo_drop;
    logic [6:0]       drop_inc;
    logic [7:0]       drop_base;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_next;
    logic             overflow_next;
    logic [NCH-1:0]   pending_next;

    always_comb begin
        arm_kept      = arm & ~drain_oh;
        arm_new       = edges & mask & ~arm_kept;
        conflicts     = edges & mask & arm_kept;
        arm_next      = arm_kept | arm_new;
        push_ok       = drain_valid && (!fifo_full || pop);
        fifo_drop     = drain_valid && fifo_full && !pop;
        drop_inc      = 7'($countones(conflicts)) + 7'(fifo_drop);
        drop_base     = clr_status ? 8'd0 : drop_cnt;
        drop_sum      = 9'(drop_base) + 9'(drop_inc);
        drop_next     = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        overflow_next = (overflow && !clr_status) || (drop_inc != '0);
        pending_next  = (wr_pending ? (pending & ~Wdata[NCH-1:0]) : pending) | edges;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            pending   <= '0;
            mask      <= '0;
            prev_seen <= '1;
            arm       <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            irq       <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable <= Wdata[0];
                irq_en <= Wdata[1];
            end
            if (wr_mask) begin
                mask <= Wdata[NCH-1:0];
            end
            pending   <= pending_next;
            prev_seen <= CorrSeen;
            arm       <= arm_next;
            overflow  <= overflow_next;
            drop_cnt  <= drop_next;
            irq       <= irq_en && |(pending & mask);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                ts_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (arm_new[i]) begin
                    ts_q[i] <= SampleCount;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_ch[i] <= '0;
                fifo_ts[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                fifo_ch[wr_ptr] <= drain_ch;
                fifo_ts[wr_ptr] <= drain_ts;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    logic [31:0] status_word;
    logic [31:0] rdata_sel;

    always_comb begin
        status_word        = '0;
        status_word[4:0]   = 5'(count);
        status_word[8]     = fifo_empty;
        status_word[9]     = fifo_full;
        status_word[16]    = overflow;
        status_word[31:24] = drop_cnt;

        rdata_sel = '0;
        case (addr)
            ADDR_CTRL:    rdata_sel = {30'd0, irq_en, enable};
            ADDR_PENDING: rdata_sel = 32'(pending);
            ADDR_MASK:    rdata_sel = 32'(mask);
            ADDR_STATUS:  rdata_sel = status_word;
            ADDR_HEAD_TS: rdata_sel = fifo_empty ? 32'd0 : 32'(fifo_ts[rd_ptr]);
            ADDR_POP:     rdata_sel = fifo_empty ? 32'd0 : {1'b1, 26'd0, fifo_ch[rd_ptr]};
            default:      rdata_sel = '0;
        endcase
    end

    assign Rdata = (rst && read) ? rdata_sel : 32'd0;

endmodule

// File: tb/tb_corr_event_collector.sv
// Self-checking bench for corr_event_collector: register table, directed corner cases,
// and randomized traffic compared against a queue-based reference model.
module tb_corr_event_collector;

    localparam int DEPTH = 16;

    localparam logic [31:0] A_CTRL = 32'hFE00_0900;
    localparam logic [31:0] A_PEND = 32'hFE00_0904;
    localparam logic [31:0] A_MASK = 32'hFE00_0908;
    localparam logic [31:0] A_STAT = 32'hFE00_090C;
    localparam logic [31:0] A_HTS  = 32'hFE00_0910;
    localparam logic [31:0] A_POP  = 32'hFE00_0914;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] Wdata = '0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] Rdata;
    logic [31:0] CorrSeen = '0;
    logic [31:0] SampleCount = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    corr_event_collector #(.NCH(32), .DEPTH(DEPTH), .TSW(32)) dut (
        .clk(clk), .rst(rst), .addr(addr), .Wdata(Wdata), .write(write), .read(read),
        .Rdata(Rdata), .CorrSeen(CorrSeen), .SampleCount(SampleCount), .irq(irq)
    );

    // Reference model: event queue plus per-channel bookkeeping, advanced once per clock.
    typedef struct packed { logic [4:0] ch; logic [31:0] ts; } ev_t;
    ev_t         mq[$];
    logic [31:0] m_pend, m_mask, m_prev, m_arm;
    logic [31:0] m_ts [32];
    bit          m_en, m_ien, m_ovf, m_irq;
    int          m_drop;

    task automatic m_reset();
        mq.delete();
        m_pend = '0; m_mask = '0; m_prev = '1; m_arm = '0;
        for (int i = 0; i < 32; i++) m_ts[i] = '0;
        m_en = 0; m_ien = 0; m_ovf = 0; m_irq = 0; m_drop = 0;
    endtask

    task automatic model_step();
        logic [31:0] edges;
        int  drops, pre_size, dch;
        bit  have, pop, irq_next;
        ev_t ev;
        irq_next = m_ien && ((m_pend & m_mask) != 0);
        pre_size = mq.size();
        pop = read && (addr == A_POP) && (pre_size != 0);
        have = 0; dch = 0;
        for (int i = 0; i < 32; i++) begin
            if (m_arm[i]) begin dch = i; have = 1; break; end
        end
        edges = m_en ? (CorrSeen & ~m_prev) : 32'd0;
        drops = 0;
        if (pop) void'(mq.pop_front());
        if (have) begin
            m_arm[dch] = 1'b0;
            if (pre_size < DEPTH || pop) begin
                ev.ch = 5'(dch); ev.ts = m_ts[dch];
                mq.push_back(ev);
            end else drops++;
        end
        for (int n = 0; n < 32; n++) begin
            if (edges[n] && m_mask[n]) begin
                if (m_arm[n]) drops++;
                else begin m_arm[n] = 1'b1; m_ts[n] = SampleCount; end
            end
        end
        if (write && addr == A_PEND) m_pend = m_pend & ~Wdata;
        m_pend = m_pend | edges;
        if (write && addr == A_MASK) m_mask = Wdata;
        if (write && addr == A_CTRL) begin m_en = Wdata[0]; m_ien = Wdata[1]; end
        if (write && addr == A_STAT && Wdata[16]) begin m_ovf = 0; m_drop = 0; end
        if (drops > 0) begin
            m_ovf = 1;
            m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
        end
        m_prev = CorrSeen;
        m_irq = irq_next;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] st;
        st = '0;
        case (a)
            A_CTRL: return {30'd0, m_ien, m_en};
            A_PEND: return m_pend;
            A_MASK: return m_mask;
            A_STAT: begin
                st[4:0]   = 5'(mq.size());
                st[8]     = (mq.size() == 0);
                st[9]     = (mq.size() == DEPTH);
                st[16]    = m_ovf;
                st[31:24] = 8'(m_drop);
                return st;
            end
            A_HTS:  return (mq.size() != 0) ? mq[0].ts : 32'd0;
            A_POP:  return (mq.size() != 0) ? {1'b1, 26'd0, mq[0].ch} : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        checkOutput("irq_model", {31'd0, irq}, {31'd0, m_irq});
        SampleCount = SampleCount + 1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; Wdata = d; write = 1'b1;
        tick();
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; read = 1'b1;
        #1;
        d = Rdata;
        checkOutput($sformatf("rd_model_%h", a), d, m_read(a));
        tick();
        read = 1'b0;
    endtask

    task automatic expect_read(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        checkOutput(name, d, exp);
    endtask

    task automatic do_reset(input string tag);
        write = 1'b0; rst = 1'b0; addr = A_STAT; read = 1'b1;
        m_reset();
        #1;
        checkOutput({tag, "_rdata_in_reset"}, Rdata, 32'd0);
        checkOutput({tag, "_irq_in_reset"}, {31'd0, irq}, 32'd0);
        read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic applyStimulus();
        logic [31:0] d;
        int op;
        for (int c = 0; c < 800; c++) begin
            CorrSeen = CorrSeen ^ ($urandom & $urandom & $urandom);
            op = $urandom_range(0, 9);
            case (op)
                0, 1, 2: bus_read(A_POP, d);
                3:       bus_read(A_CTRL + 32'(4 * $urandom_range(0, 5)), d);
                4:       bus_write(A_PEND, $urandom);
                5:       if ($urandom_range(0, 7) == 0) bus_write(A_MASK, $urandom); else tick();
                6:       if ($urandom_range(0, 15) == 0) bus_write(A_STAT, 32'h0001_0000); else tick();
                7:       if ($urandom_range(0, 31) == 0) bus_write(A_CTRL, 32'($urandom_range(0, 3))); else tick();
                default: tick();
            endcase
        end
        CorrSeen = '0;
        for (int i = 0; i < 6; i++) bus_read(A_CTRL + 32'(4 * i), d);
    endtask

    typedef struct {
        bit          is_write;
        logic [31:0] a;
        logic [31:0] d;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [31:0] d;
        int          chs[3];

        vecs[0]  = '{1'b0, A_CTRL, 32'h0000_0000};
        vecs[1]  = '{1'b0, A_PEND, 32'h0000_0000};
        vecs[2]  = '{1'b0, A_MASK, 32'h0000_0000};
        vecs[3]  = '{1'b0, A_STAT, 32'h0000_0100};
        vecs[4]  = '{1'b0, A_HTS,  32'h0000_0000};
        vecs[5]  = '{1'b0, A_POP,  32'h0000_0000};
        vecs[6]  = '{1'b0, 32'hFE00_0918, 32'h0000_0000};
        vecs[7]  = '{1'b1, A_MASK, 32'hA5A5_0F0F};
        vecs[8]  = '{1'b0, A_MASK, 32'hA5A5_0F0F};
        vecs[9]  = '{1'b1, A_CTRL, 32'hFFFF_FFFE};
        vecs[10] = '{1'b0, A_CTRL, 32'h0000_0002};
        vecs[11] = '{1'b0, 32'hFE00_08FC, 32'h0000_0000};

        do_reset("vec");
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_write) bus_write(vecs[i].a, vecs[i].d);
            else begin
                bus_read(vecs[i].a, d);
                checkOutput($sformatf("vec%0d", i), d, vecs[i].d);
            end
        end

        // Single edge: timestamp, pop format, W1C clears irq
        do_reset("t1");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, 32'h1 << 21);
        SampleCount = 32'h1234;
        CorrSeen = 32'h1 << 21;
        tick();
        CorrSeen = '0;
        tick();
        checkOutput("t1_irq_set", {31'd0, irq}, 32'd1);
        expect_read("t1_count1", A_STAT, 32'h0000_0001);
        expect_read("t1_head_ts", A_HTS, 32'h0000_1234);
        expect_read("t1_pop", A_POP, 32'h8000_0015);
        expect_read("t1_count0", A_STAT, 32'h0000_0100);
        bus_write(A_PEND, 32'h1 << 21);
        tick();
        checkOutput("t1_irq_clear", {31'd0, irq}, 32'd0);

        // Simultaneous edges drain in ascending channel order
        do_reset("t2");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        SampleCount = 32'h55;
        CorrSeen = (32'h1 << 3) | (32'h1 << 7) | (32'h1 << 21);
        tick();
        CorrSeen = '0;
        repeat (3) tick();
        expect_read("t2_count3", A_STAT, 32'h0000_0003);
        chs[0] = 3; chs[1] = 7; chs[2] = 21;
        for (int i = 0; i < 3; i++) begin
            expect_read($sformatf("t2_ts%0d", i), A_HTS, 32'h55);
            expect_read($sformatf("t2_pop%0d", i), A_POP, 32'h8000_0000 | 32'(chs[i]));
        end
        expect_read("t2_empty", A_STAT, 32'h0000_0100);

        // Full FIFO: drop, then pop concurrent with edge and with push
        do_reset("t3");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        SampleCount = 32'h300;
        CorrSeen = 32'h0001_FFFF;
        tick();
        CorrSeen = '0;
        repeat (17) tick();
        expect_read("t3_full_drop", A_STAT, 32'h0101_0210);
        expect_read("t3_head_ts", A_HTS, 32'h300);
        CorrSeen = 32'h1 << 20;
        expect_read("t3_pop_ch0", A_POP, 32'h8000_0000);
        CorrSeen = '0;
        tick();
        expect_read("t3_refill", A_STAT, 32'h0101_0210);
        CorrSeen = 32'h1 << 22;
        tick();
        CorrSeen = '0;
        expect_read("t3_pop_ch1", A_POP, 32'h8000_0001);
        expect_read("t3_push_pop_full", A_STAT, 32'h0101_0210);
        bus_write(A_STAT, 32'h0001_0000);
        expect_read("t3_ovf_clear", A_STAT, 32'h0000_0210);

        // Unmasked channel: pending only, irq follows later mask write
        do_reset("t4");
        bus_write(A_CTRL, 32'h3);
        CorrSeen = 32'h1 << 5;
        tick();
        CorrSeen = '0;
        tick();
        expect_read("t4_pending", A_PEND, 32'h0000_0020);
        checkOutput("t4_irq_masked", {31'd0, irq}, 32'd0);
        expect_read("t4_no_entry", A_STAT, 32'h0000_0100);
        bus_write(A_MASK, 32'h20);
        checkOutput("t4_irq_same_cycle", {31'd0, irq}, 32'd0);
        tick();
        checkOutput("t4_irq_unmasked", {31'd0, irq}, 32'd1);

        // Flag high through reset release creates no event until it re-rises
        CorrSeen = 32'h1 << 9;
        do_reset("t5");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        tick();
        expect_read("t5_no_pending", A_PEND, 32'h0);
        expect_read("t5_no_event", A_STAT, 32'h0000_0100);
        CorrSeen = '0;
        tick();
        CorrSeen = 32'h1 << 9;
        tick();
        CorrSeen = '0;
        tick();
        expect_read("t5_one_event", A_STAT, 32'h0000_0001);
        expect_read("t5_pop", A_POP, 32'h8000_0009);

        // Reset mid-drain flushes everything at once
        do_reset("t6a");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, 32'hFFFF_FFFF);
        CorrSeen = 32'hF;
        tick();
        CorrSeen = '0;
        repeat (2) tick();
        checkOutput("t6_irq_before", {31'd0, irq}, 32'd1);
        do_reset("t6");
        expect_read("t6_pop_empty", A_POP, 32'h0);
        expect_read("t6_status", A_STAT, 32'h0000_0100);

        // Randomized traffic against the model
        do_reset("rand");
        bus_write(A_CTRL, 32'h3);
        bus_write(A_MASK, $urandom | $urandom);
        applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/corr_event_collector.md
Name: corr_event_collector

Overview:
- Sits directly downstream of the correlator channels and consumes their per-channel CorrelationSeen flags.
- Detects rising edges of each flag and timestamps every new detection with the global SampleCount.
- Enqueues {channel, timestamp} into an event FIFO that the CPU drains over the same addr/Wdata/Rdata bus the correlators use.
- Raises a maskable interrupt while any unmasked detection is pending.

Parameters:
NCH, 32, number of correlator channels (max 32)
DEPTH, 16, event FIFO depth, power of 2
TSW, 32, timestamp width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
addr  in  32  bus address
Wdata  in  32  bus write data
write  in  1  single-cycle write strobe
read  in  1  single-cycle read strobe
Rdata  out  32  read data, combinational from addr/read
CorrSeen  in  NCH  CorrelationSeen flags; bit n from correlator n
SampleCount  in  TSW  global sample counter
irq  out  1  registered interrupt

Behaviour:
- Reset (rst=0, async): all registers 0, except prev_seen = all ones, so channels already high raise no event. irq=0; Rdata=0 while reset is asserted.
- Register map:
  - FE000900 CTRL rw: [0] enable, [1] irq_en.
  - FE000904 PENDING: read; write-1-to-clear.
  - FE000908 MASK rw: 1 = enqueue and interrupt enabled for that channel.
  - FE00090C STATUS ro: [4:0] count, [8] empty, [9] full, [16] overflow sticky, [31:24] drop_cnt (saturates at 255).
  - FE000910 HEAD_TS ro: timestamp of head entry, no side effect.
  - FE000914 HEAD_POP: read returns {valid[31], 26'b0, ch[4:0]} and pops one entry if non-empty; empty read returns 0.
  - Write 1 to STATUS[16] clears overflow and drop_cnt.
  - Unmapped reads return 0.
- Edge detect:
  - Each clock: prev_seen <= CorrSeen; edge = CorrSeen & ~prev_seen, gated by enable.
  - Edge on n at edge k: PENDING[n] set. If MASK[n] is also set, arm[n]=1 and ts[n]=SampleCount sampled at edge k.
  - Same cycle as a W1C clear of n: the set wins.
- Second edge on n while arm[n] still set: ts[n] is not overwritten; overflow=1 and drop_cnt+1.
- Drain:
  - Each cycle, the lowest-index armed channel is pushed as {n, ts[n]} and arm[n] is cleared: one push per cycle.
  - Latency is one cycle: a single edge at edge k gives count+1 visible after edge k+1.
  - M simultaneous edges drain in ascending channel order over M cycles.
- FIFO full:
  - Push with no pop in the same cycle: entry dropped, arm[n] cleared, overflow=1, drop_cnt+1.
  - Push and pop in the same cycle: both occur, count unchanged, no drop.
- Pop on empty: no change.
- Pointers wrap mod DEPTH; count ranges 0..DEPTH.
- irq <= irq_en & |(PENDING & MASK); asserts the cycle after the PENDING bit sets.
- Clearing enable:
  - Stops new edges; armed entries still drain.
  - prev_seen keeps updating, so a flag that rose while disabled creates no event on re-enable.
- Writes and reads in the same cycle to different registers are independent.
- Reset mid-operation flushes the FIFO, PENDING and arm state immediately.

Test Plan:
1. CTRL=3, MASK=1<<21, SampleCount=0x1234. Pulse CorrSeen[21] at edge k -> after k+1: STATUS count=1, HEAD_TS=0x1234, irq=1. Read 914 -> 0x80000015, count=0. W1C PENDING bit 21 -> irq=0 next cycle.
2. MASK=all ones; channels 3, 7 and 21 rise in the same cycle -> three pops return ch 3, 7, 21 in order, all with the same timestamp; count peaks at 3.
3. DEPTH=16: fill 16 events, then one more edge -> full=1, overflow=1, drop_cnt=1, FIFO contents unchanged. Pop plus new edge in the same cycle -> count stays 16, drop_cnt stays 1.
4. MASK[5]=0, CTRL=3, edge on 5 -> PENDING[5]=1, no FIFO entry, irq=0. Set MASK[5]=1 -> irq=1 next cycle.
5. CorrSeen[9] held high through reset release -> no event. Drop to 0 and raise again -> one event.
6. Queue 4 events, assert rst=0 mid-drain -> count=0, irq=0, Rdata=0 immediately. After release, pop on empty returns 0.
